ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n_i  in  1  asynchronous, active-low reset.
REQ-003 ex_valid_i  in  1  EX-stage instruction valid, i.e. not a bubble.
REQ-004 ex_inst_i  in  32  EX-stage instruction word, taken from the ID/EX register.
REQ-005 rs_data_i  in  32  operand rs, after forwarding.
REQ-006 rt_data_i  in  32  operand rt, after forwarding.
REQ-007 flush_i  in  1  kill the EX-stage instruction this cycle.
REQ-008 id_inst_i  in  32  ID-stage instruction word, used for interlock.
REQ-009 stall_o  out  1  hold PC and IF/ID, and insert a bubble into ID/EX.
REQ-010 busy_o  out  1  iterative operation in progress.
REQ-011 hi_o, lo_o  out  32 each  architectural HI/LO registers.
REQ-012 mf_sel_o  out  1  EX result is taken from this unit (MFHI/MFLO).
REQ-013 mf_data_o  out  32  HI for MFHI, LO for MFLO, 0 otherwise.

Function
REQ-014 Decode: opcode 0 plus funct. MFHI=0x10, MTHI=0x11, MFLO=0x12, MTLO=0x13, MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B. All eight are "hilo-type".
REQ-015 Start condition: ex_valid_i=1, flush_i=0, state IDLE, funct in {MULT, MULTU, DIV, DIVU}. The unit latches rs/rt at that edge (E0) and enters MUL or DIV.
REQ-016 FSM states: IDLE, MUL, DIV.
- MUL/DIV each run exactly 32 iteration cycles.
- Result is written to HI/LO at edge E32; the FSM returns to IDLE at the same edge.
REQ-017 busy_o SHALL be 1 from E0 through E32 exclusive, i.e. exactly 32 cycles.
REQ-018 stall_o = id_inst_i hilo-type AND (busy_o OR start condition true this cycle). It is combinational.
REQ-019 MULT/MULTU: radix-2 shift-add. HI:LO = full 64-bit product; signed for MULT, unsigned for MULTU.
REQ-020 DIV/DIVU: restoring division on magnitudes.
- LO = quotient, truncated toward zero.
- HI = remainder, carrying the dividend's sign.
REQ-021 Divide by zero: LO=0xFFFFFFFF, HI=rs; still takes 32 cycles.
REQ-022 DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-023 MTHI/MTLO (valid, not flushed, IDLE): write rs into HI/LO at the next edge; single cycle, no busy.
REQ-024 MFHI/MFLO in EX: mf_sel_o=1 and mf_data_o=current hi_o/lo_o, same cycle, no latency.
REQ-025 flush_i=1 suppresses start and MT writes for that cycle. It does not abort an operation already running.
REQ-026 Hilo-type instruction in EX while busy: ignored, with no state change. The REQ-018 interlock prevents this case.
REQ-027 A start on the same edge as E32 cannot occur, because of the interlock; no back-to-back overlap is supported.

Reset
REQ-028 rst_n_i low SHALL immediately force:
- state IDLE, iteration counter 0;
- HI=0, LO=0;
- busy_o=0, stall_o from busy term 0.
REQ-029 Reset mid-operation discards the partial result.
REQ-030 Operation resumes on the first rising edge after rst_n_i returns high.

Structure
REQ-031 Shared package contents:
- funct constants (REQ-014);
- FSM state enum;
- ITER_CYCLES=32.
REQ-032 One sub-module, ex_div_iter (restoring divider core: start, done, quotient, remainder). The multiply datapath stays in ex_muldiv.
REQ-033 Target size: 120-400 lines of RTL. No memories. No multiplier or divider operators inferred.

Verification
REQ-034 MULT rs=7, rt=0xFFFFFFFD -> busy_o 32 cycles; after E32 HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIVU rs=10, rt=0 -> LO=0xFFFFFFFF, HI=0x0000000A.
REQ-037 Interlock: MULT in EX while MFLO is in ID -> stall_o high for 33 consecutive cycles. Next cycle MFLO in EX -> mf_sel_o=1 and mf_data_o equals the new LO.
REQ-038 Flush: MULT with flush_i=1 -> busy_o stays 0 and HI/LO are unchanged.
REQ-039 Reset mid-operation: rst_n_i low at iteration 10 of DIV -> busy_o=0 and HI=LO=0 immediately. A following MTLO rs=0x1234 -> LO=0x00001234 one cycle later.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_pkg
// Shared definitions for the EX-stage multiply/divide unit: instruction
// function codes for the HI/LO group, the iteration FSM state type, the
// number of iteration cycles, and small decode helpers used by both the
// unit itself and its divider core.
// ---------------------------------------------------------------------------
package ex_muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam int ITER_CYCLES = 32;

  // Counter value seen during the final iteration cycle.
  localparam logic [4:0] LAST_ITER = 5'(ITER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // True for any of the eight HI/LO instructions (SPECIAL opcode).
  function automatic logic is_hilo(input logic [31:0] inst);
    logic [5:0] funct;
    funct = inst[5:0];
    return (inst[31:26] == 6'd0) &&
           ((funct == FUNCT_MFHI)  || (funct == FUNCT_MTHI)  ||
            (funct == FUNCT_MFLO)  || (funct == FUNCT_MTLO)  ||
            (funct == FUNCT_MULT)  || (funct == FUNCT_MULTU) ||
            (funct == FUNCT_DIV)   || (funct == FUNCT_DIVU));
  endfunction

  // True for the four iterative instructions (MULT/MULTU/DIV/DIVU).
  function automatic logic is_muldiv(input logic [31:0] inst);
    logic [5:0] funct;
    funct = inst[5:0];
    return (inst[31:26] == 6'd0) &&
           ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
            (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU));
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// ---------------------------------------------------------------------------
// ex_div_iter
// Restoring unsigned divider core, one quotient bit per clock.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset (abandons any division)
//   start_i      load operands and begin a 32-step division
//   dividend_i   unsigned dividend, sampled with start_i
//   divisor_i    unsigned divisor, sampled with start_i
//   done_o       high during the last iteration cycle
//   quotient_o   quotient produced by the step taken at the coming edge
//   remainder_o  remainder produced by the step taken at the coming edge
//
// quotient_o/remainder_o are the combinational next-step values so that the
// owner can capture the final result on the same edge the last step happens,
// while done_o is high.
// ---------------------------------------------------------------------------
module ex_div_iter
  import ex_muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic        running_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  // One restoring step: bring down the next dividend bit (taken from the top
  // of the quotient shift register), try subtracting the divisor, and keep
  // the difference only when it did not borrow. The remainder is always
  // below the divisor, so a borrow shows up as bit 32 of the trial result.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    if (trial[32]) begin
      rem_nxt = shifted[31:0];
      quo_nxt = {quo_q[30:0], 1'b0};
    end else begin
      rem_nxt = trial[31:0];
      quo_nxt = {quo_q[30:0], 1'b1};
    end
  end

  // Operand load on start, then one step per cycle until the counter has
  // covered every dividend bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      running_q <= 1'b0;
      cnt_q     <= 5'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
    end else if (start_i) begin
      running_q <= 1'b1;
      cnt_q     <= 5'd0;
      rem_q     <= 32'd0;
      quo_q     <= dividend_i;
      dvs_q     <= divisor_i;
    end else if (running_q) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == LAST_ITER) begin
        running_q <= 1'b0;
      end
    end
  end

  assign done_o      = running_q && (cnt_q == LAST_ITER);
  assign quotient_o  = quo_nxt;
  assign remainder_o = rem_nxt;

endmodule

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU use a radix-2 shift-add datapath on operand magnitudes;
// DIV/DIVU use the ex_div_iter restoring core. Both take 32 cycles, with the
// sign correction applied as the result is written to HI/LO.
//
// Ports
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   ex_valid_i  EX instruction is real (not a bubble)
//   ex_inst_i   EX instruction word
//   rs_data_i   forwarded rs operand
//   rt_data_i   forwarded rt operand
//   flush_i     kill the EX instruction this cycle
//   id_inst_i   ID instruction word, for the HI/LO interlock
//   stall_o     hold PC and IF/ID, bubble into ID/EX
//   busy_o      iterative operation in progress
//   hi_o, lo_o  architectural HI/LO
//   mf_sel_o    EX result comes from this unit (MFHI/MFLO)
//   mf_data_o   HI for MFHI, LO for MFLO, zero otherwise
// ---------------------------------------------------------------------------
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_inst_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        flush_i,
  input  logic [31:0] id_inst_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mf_sel_o,
  output logic [31:0] mf_data_o
);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] mcand_q;
  logic [63:0] acc_q;
  logic        prod_neg_q;

  logic [31:0] rs_q;
  logic        div_zero_q;
  logic        quo_neg_q;
  logic        rem_neg_q;

  logic [5:0]  ex_funct;
  logic        ex_special;
  logic        ex_live;
  logic        start;
  logic        div_start;
  logic        op_signed;
  logic        mt_write;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;

  logic [32:0] mul_sum;
  logic [63:0] acc_nxt;
  logic [63:0] prod_final;

  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  // EX decode. Even function codes (MULT, DIV) are the signed variants.
  // Operands are reduced to magnitudes so both datapaths stay unsigned;
  // 0x80000000 negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    ex_funct   = ex_inst_i[5:0];
    ex_special = (ex_inst_i[31:26] == 6'd0);
    ex_live    = ex_valid_i && !flush_i && (state_q == ST_IDLE);
    start      = ex_live && is_muldiv(ex_inst_i);
    div_start  = start && ex_funct[1];
    op_signed  = !ex_funct[0];
    mt_write   = ex_live && ex_special &&
                 ((ex_funct == FUNCT_MTHI) || (ex_funct == FUNCT_MTLO));
    rs_mag     = (op_signed && rs_data_i[31]) ? (32'd0 - rs_data_i) : rs_data_i;
    rt_mag     = (op_signed && rt_data_i[31]) ? (32'd0 - rt_data_i) : rt_data_i;
  end

  // Shift-add step: the multiplier sits in the low half of the accumulator
  // and is consumed LSB first; the partial product grows into the high half.
  // The 33-bit sum keeps the carry that is shifted down into bit 63.
  always_comb begin
    mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    acc_nxt    = {mul_sum, acc_q[31:1]};
    prod_final = prod_neg_q ? (64'd0 - acc_nxt) : acc_nxt;
  end

  ex_div_iter u_div_iter (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (div_start),
    .dividend_i  (rs_mag),
    .divisor_i   (rt_mag),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Division sign fix-up: quotient negative when operand signs differ,
  // remainder follows the dividend. Divide-by-zero bypasses the core result
  // entirely, returning all-ones and the original rs.
  always_comb begin
    if (div_zero_q) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = rs_q;
    end else begin
      div_lo = quo_neg_q ? (32'd0 - div_quo) : div_quo;
      div_hi = rem_neg_q ? (32'd0 - div_rem) : div_rem;
    end
  end

  // Main FSM. A start in IDLE latches operands and sign information; the
  // MUL and DIV states iterate until the final step, whose result lands in
  // HI/LO on the same edge the FSM returns to IDLE. MTHI/MTLO write only
  // from IDLE, so a HI/LO instruction that reaches EX while busy is ignored.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      mcand_q    <= 32'd0;
      acc_q      <= 64'd0;
      prod_neg_q <= 1'b0;
      rs_q       <= 32'd0;
      div_zero_q <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q <= 5'd0;
            if (div_start) begin
              state_q    <= ST_DIV;
              rs_q       <= rs_data_i;
              div_zero_q <= (rt_data_i == 32'd0);
              quo_neg_q  <= op_signed && (rs_data_i[31] ^ rt_data_i[31]);
              rem_neg_q  <= op_signed && rs_data_i[31];
            end else begin
              state_q    <= ST_MUL;
              mcand_q    <= rt_mag;
              acc_q      <= {32'd0, rs_mag};
              prod_neg_q <= op_signed && (rs_data_i[31] ^ rt_data_i[31]);
            end
          end else if (mt_write) begin
            if (ex_funct == FUNCT_MTHI) begin
              hi_q <= rs_data_i;
            end else begin
              lo_q <= rs_data_i;
            end
          end
        end
        ST_MUL: begin
          acc_q <= acc_nxt;
          if (cnt_q == LAST_ITER) begin
            hi_q    <= prod_final[63:32];
            lo_q    <= prod_final[31:0];
            cnt_q   <= 5'd0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            hi_q    <= div_hi;
            lo_q    <= div_lo;
            cnt_q   <= 5'd0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

  // Outputs. The interlock also covers the start cycle itself, so an HI/LO
  // instruction in ID never overtakes the operation that is just launching.
  always_comb begin
    busy_o   = (state_q != ST_IDLE);
    stall_o  = is_hilo(id_inst_i) && (busy_o || start);
    mf_sel_o = ex_valid_i && ex_special &&
               ((ex_funct == FUNCT_MFHI) || (ex_funct == FUNCT_MFLO));
    if (!mf_sel_o) begin
      mf_data_o = 32'd0;
    end else if (ex_funct == FUNCT_MFHI) begin
      mf_data_o = hi_q;
    end else begin
      mf_data_o = lo_q;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv
// Self-checking bench for ex_muldiv: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for interlock, flush, MT/MF and reset-during-operation.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic [31:0] id_inst;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mf_sel;
  logic [31:0] mf_data;

  int tests;
  int failed;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  ex_muldiv dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ex_valid_i (ex_valid),
    .ex_inst_i  (ex_inst),
    .rs_data_i  (rs_data),
    .rt_data_i  (rt_data),
    .flush_i    (flush),
    .id_inst_i  (id_inst),
    .stall_o    (stall),
    .busy_o     (busy),
    .hi_o       (hi),
    .lo_o       (lo),
    .mf_sel_o   (mf_sel),
    .mf_data_o  (mf_data)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a hung DUT still produces a report.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [5:0] f);
    return {26'd0, f};
  endfunction

  // Reference model: the architectural result from plain arithmetic.
  function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rhi, output logic [31:0] rlo);
    longint          ps;
    longint unsigned pu;
    int              sa;
    int              sb;
    sa = $signed(a);
    sb = $signed(b);
    rhi = 32'd0;
    rlo = 32'd0;
    case (f)
      F_MULT: begin
        ps  = longint'(sa) * longint'(sb);
        rhi = ps[63:32];
        rlo = ps[31:0];
      end
      F_MULTU: begin
        pu  = {32'd0, a} * {32'd0, b};
        rhi = pu[63:32];
        rlo = pu[31:0];
      end
      F_DIV: begin
        if (b == 32'd0) begin
          rlo = 32'hFFFF_FFFF;
          rhi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rlo = 32'h8000_0000;
          rhi = 32'd0;
        end else begin
          rlo = sa / sb;
          rhi = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          rlo = 32'hFFFF_FFFF;
          rhi = a;
        end else begin
          rlo = a / b;
          rhi = a % b;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] a,
                               input logic [31:0] b, input logic fl, input logic [31:0] idi);
    ex_valid = v;
    ex_inst  = inst;
    rs_data  = a;
    rt_data  = b;
    flush    = fl;
    id_inst  = idi;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issue one iterative op for a single cycle, wait for busy to drop with a
  // bounded loop, then check the busy length and the HI/LO result.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int cycles;
    applyStimulus(1'b1, mk(f), a, b, 1'b0, NOP);
    tick();
    applyStimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, NOP);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
    checkOutput({name, "_busy_cycles"}, 64'(cycles), 64'd32);
    checkOutput({name, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    checkOutput({name, "_lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mhi;
    logic [31:0] mlo;
    int          stall_cnt;
    int          guard;
    logic [5:0]  ops[4];

    tests  = 0;
    failed = 0;
    ops[0] = F_MULT;
    ops[1] = F_MULTU;
    ops[2] = F_DIV;
    ops[3] = F_DIVU;

    vecs[0] = '{F_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{F_DIVU,  32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF};
    vecs[4] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{F_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[6] = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{F_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[8] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{F_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};

    // Reset state while reset is held.
    rst_n = 1'b0;
    applyStimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, mk(F_MFHI));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_stall", {63'd0, stall}, 64'd0);
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, NOP);
    tick();

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].funct, vecs[i].rs, vecs[i].rt,
             vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      f = ops[$urandom_range(0, 3)];
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      ref_op(f, a, b, mhi, mlo);
      run_op($sformatf("rnd%0d_f%0h", i, f), f, a, b, mhi, mlo);
    end

    // MTHI/MTLO single-cycle writes and MFHI/MFLO same-cycle reads.
    applyStimulus(1'b1, mk(F_MTHI), 32'hAAAA_5555, 32'd0, 1'b0, NOP);
    #1;
    checkOutput("mthi_no_busy", {63'd0, busy}, 64'd0);
    tick();
    checkOutput("mthi_hi", {32'd0, hi}, {32'd0, 32'hAAAA_5555});
    applyStimulus(1'b1, mk(F_MTLO), 32'h0F0F_1234, 32'd0, 1'b0, NOP);
    tick();
    checkOutput("mtlo_lo", {32'd0, lo}, {32'd0, 32'h0F0F_1234});
    applyStimulus(1'b1, mk(F_MFHI), 32'd0, 32'd0, 1'b0, NOP);
    #1;
    checkOutput("mfhi_sel", {63'd0, mf_sel}, 64'd1);
    checkOutput("mfhi_data", {32'd0, mf_data}, {32'd0, 32'hAAAA_5555});
    applyStimulus(1'b1, mk(F_MFLO), 32'd0, 32'd0, 1'b0, NOP);
    #1;
    checkOutput("mflo_data", {32'd0, mf_data}, {32'd0, 32'h0F0F_1234});
    applyStimulus(1'b1, mk(F_MTHI), 32'd0, 32'd0, 1'b0, NOP);
    #1;
    checkOutput("mthi_sel_low", {63'd0, mf_sel}, 64'd0);
    checkOutput("mthi_data_zero", {32'd0, mf_data}, 64'd0);
    applyStimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, NOP);
    tick();

    // Flushed MULT and flushed MTHI leave everything untouched.
    applyStimulus(1'b1, mk(F_MULT), 32'd3, 32'd4, 1'b1, mk(F_MFLO));
    #1;
    checkOutput("flush_stall", {63'd0, stall}, 64'd0);
    tick();
    applyStimulus(1'b1, mk(F_MTHI), 32'hDEAD_BEEF, 32'd0, 1'b1, NOP);
    tick();
    applyStimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, NOP);
    tick();
    checkOutput("flush_busy", {63'd0, busy}, 64'd0);
    checkOutput("flush_hi", {32'd0, hi}, {32'd0, 32'hAAAA_5555});
    checkOutput("flush_lo", {32'd0, lo}, {32'd0, 32'h0F0F_1234});

    // Interlock: MULT in EX with MFLO in ID stalls 33 cycles, then MFLO
    // in EX returns the fresh LO.
    applyStimulus(1'b1, mk(F_MULT), 32'd5, 32'hFFFF_FFFA, 1'b0, mk(F_MFLO));
    #1;
    stall_cnt = 0;
    guard     = 0;
    while (stall && guard < 100) begin
      stall_cnt++;
      guard++;
      tick();
      applyStimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, mk(F_MFLO));
      #1;
    end
    checkOutput("interlock_stall_cycles", 64'(stall_cnt), 64'd33);
    applyStimulus(1'b1, mk(F_MFLO), 32'd0, 32'd0, 1'b0, NOP);
    #1;
    checkOutput("interlock_mf_sel", {63'd0, mf_sel}, 64'd1);
    checkOutput("interlock_mf_data", {32'd0, mf_data}, {32'd0, 32'hFFFF_FFE2});
    checkOutput("interlock_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
    tick();
    applyStimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, NOP);
    tick();

    // Reset in the middle of a DIV, then an MTLO after release.
    applyStimulus(1'b1, mk(F_DIV), 32'd1000, 32'd3, 1'b0, NOP);
    tick();
    applyStimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, mk(F_MFHI));
    repeat (10) tick();
    checkOutput("midop_busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midop_reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("midop_reset_stall", {63'd0, stall}, 64'd0);
    checkOutput("midop_reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("midop_reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, mk(F_MTLO), 32'h0000_1234, 32'd0, 1'b0, NOP);
    tick();
    applyStimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, NOP);
    checkOutput("post_reset_mtlo_lo", {32'd0, lo}, {32'd0, 32'h0000_1234});
    checkOutput("post_reset_hi", {32'd0, hi}, 64'd0);
    repeat (40) tick();
    checkOutput("post_reset_idle", {63'd0, busy}, 64'd0);
    checkOutput("post_reset_lo_kept", {32'd0, lo}, {32'd0, 32'h0000_1234});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
